// File: rtl/lcd_cmd_sequencer.sv
// HD44780 bus sequencer: one command/data byte per valid/ready handshake, 8-bit or 4-bit bus.
// Defining LCD_INIT_SEQ_EN adds the power-on initialisation sequence ahead of IDLE.
module lcd_cmd_sequencer #(
    parameter int FOUR_BIT = 0,
    parameter int T_SETUP  = 2,
    parameter int E_PULSE  = 12,
    parameter int T_EXEC   = 2000,
    parameter int T_CLEAR  = 80000,
    parameter int T_PWRUP  = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);
    localparam int MAX_A = (T_SETUP > E_PULSE) ? T_SETUP : E_PULSE;
    localparam int MAX_B = (MAX_A > T_EXEC) ? MAX_A : T_EXEC;
    localparam int MAX_C = (MAX_B > T_CLEAR) ? MAX_B : T_CLEAR;
    localparam int MAX_D = (MAX_C > T_PWRUP) ? MAX_C : T_PWRUP;
    localparam int CW    = $clog2(MAX_D) + 1;

    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_EPULS = CW'(E_PULSE - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] L_CLEAR = CW'(T_CLEAR - 1);

    typedef enum logic [2:0] {PWRUP, IDLE, SETUP, EHIGH, SETUP2, EHIGH2, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    lo_nib;
    logic          single;
    logic          long_wait;
    logic          load;
    logic          ld_rs;
    logic [7:0]    ld_data;
    logic          ld_single;
    logic          ld_long;

`ifdef LCD_INIT_SEQ_EN
    localparam logic [CW-1:0] L_PWRUP  = CW'(T_PWRUP - 1);
    localparam logic [3:0]    CMD_BASE = (FOUR_BIT != 0) ? 4'd4 : 4'd3;
    localparam logic [3:0]    N_STEPS  = CMD_BASE + 4'd5;
    logic [3:0] step;
`endif

    assign lcd_rw = 1'b0;

    // Next transfer source: the handshake byte, or the current init table entry while not initialised.
    always_comb begin
        ld_rs     = cmd_rs;
        ld_data   = cmd_data;
        ld_single = 1'b0;
        ld_long   = ~cmd_rs & (cmd_data[7:1] == 7'd0);
        load      = (state == IDLE) & cmd_valid & cmd_ready;
`ifdef LCD_INIT_SEQ_EN
        if (!init_done) begin
            ld_rs = 1'b0;
            if (step < 4'd3) begin
                ld_data   = 8'h30;
                ld_single = 1'b1;
                ld_long   = 1'b1;
            end else if (FOUR_BIT != 0 && step == 4'd3) begin
                ld_data   = 8'h20;
                ld_single = 1'b1;
                ld_long   = 1'b0;
            end else begin
                case (step - CMD_BASE)
                    4'd0:    ld_data = (FOUR_BIT != 0) ? 8'h28 : 8'h38;
                    4'd1:    ld_data = 8'h08;
                    4'd2:    ld_data = 8'h01;
                    4'd3:    ld_data = 8'h06;
                    default: ld_data = 8'h0C;
                endcase
                ld_long = (ld_data[7:1] == 7'd0);
            end
            load = (state == WAIT) & (cnt == '0) & (step != N_STEPS);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef LCD_INIT_SEQ_EN
            state <= PWRUP;
            step  <= 4'd0;
`else
            state <= IDLE;
`endif
            cnt       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_db    <= 8'h00;
            lo_nib    <= 4'h0;
            single    <= 1'b0;
            long_wait <= 1'b0;
        end else begin
            case (state)
`ifdef LCD_INIT_SEQ_EN
                PWRUP: begin
                    state <= WAIT;
                    cnt   <= L_PWRUP;
                end
`endif
                IDLE: begin
`ifndef LCD_INIT_SEQ_EN
                    init_done <= 1'b1;
`endif
                    cmd_ready <= ~load;
                    busy      <= load;
                end
                SETUP, SETUP2: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= (state == SETUP) ? EHIGH : EHIGH2;
                        lcd_e <= 1'b1;
                        cnt   <= L_EPULS;
                    end
                end
                EHIGH, EHIGH2: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        lcd_e <= 1'b0;
                        if (FOUR_BIT != 0 && state == EHIGH && !single) begin
                            state  <= SETUP2;
                            lcd_db <= {lo_nib, 4'h0};
                            cnt    <= L_SETUP;
                        end else begin
                            state <= WAIT;
                            cnt   <= long_wait ? L_CLEAR : L_EXEC;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
`ifdef LCD_INIT_SEQ_EN
                        if (!init_done) begin
                            if (step == N_STEPS) begin
                                init_done <= 1'b1;
                                state     <= IDLE;
                                cmd_ready <= 1'b1;
                            end
                        end else begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
`else
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            // A load overrides the case above: latch the byte and start the setup phase.
            if (load) begin
                state     <= SETUP;
                cnt       <= L_SETUP;
                lcd_rs    <= ld_rs;
                lcd_db    <= (FOUR_BIT != 0) ? {ld_data[7:4], 4'h0} : ld_data;
                lo_nib    <= ld_data[3:0];
                single    <= ld_single;
                long_wait <= ld_long;
`ifdef LCD_INIT_SEQ_EN
                if (!init_done) begin
                    step <= step + 4'd1;
                end
`endif
            end
        end
    end
endmodule
